// File: rtl/seg_pkg.sv
// Shared constants for the two-digit seven-segment scan driver: hex glyph
// table, direction letters and the scan state encoding.
package seg_pkg;

  // Segment order is {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_U     = 7'h3E;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    SCAN_VAL = 1'b0,
    SCAN_DIR = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_driver_hex7seg_dec.sv
// Combinational 4-bit hex to seven-segment glyph decoder.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_GLYPH[i_hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver: digit 0 = hex count, digit 1 = U/d.
// Optional wrap indicator on dp is built only when SEG_SCAN_DP_WRAP_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int WRAP_HOLD   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic       updown,
  input  logic       en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if (REFRESH_DIV < 1 || WRAP_HOLD < 1) begin : g_bad_param
    $error("seg_scan_driver: REFRESH_DIV and WRAP_HOLD must be >= 1");
  end

  logic [3:0]    r_cnt_q;
  logic          r_dir_q;
  logic [PW-1:0] r_presc;
  scan_state_e   r_state;
  logic [6:0]    r_seg;
  logic [1:0]    r_digit;
  logic [6:0]    w_val_glyph;
  logic          w_tick;

  assign w_tick = (r_presc == PW'(REFRESH_DIV - 1));

  hex7seg_dec u_val_dec (
    .i_hex (r_cnt_q),
    .o_seg (w_val_glyph)
  );

  // Capture, prescaler, scan state and registered segment/digit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_q <= 4'd0;
      r_dir_q <= 1'b0;
      r_presc <= '0;
      r_state <= SCAN_VAL;
      r_seg   <= SEG_BLANK;
      r_digit <= 2'b00;
    end else begin
      r_cnt_q <= count;
      r_dir_q <= updown;
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_state <= (r_state == SCAN_VAL) ? SCAN_DIR : SCAN_VAL;
      end
      // Digit and segments change on the same edge, so no ghosting cycle.
      if (!en) begin
        r_seg   <= SEG_BLANK;
        r_digit <= 2'b00;
      end else if (r_state == SCAN_VAL) begin
        r_seg   <= w_val_glyph;
        r_digit <= 2'b01;
      end else begin
        r_seg   <= r_dir_q ? SEG_U : SEG_D;
        r_digit <= 2'b10;
      end
    end
  end

  assign seg   = r_seg;
  assign digit = r_digit;

`ifdef SEG_SCAN_DP_WRAP_EN
  localparam int HW = $clog2(WRAP_HOLD + 1);

  logic [HW-1:0] r_hold;
  logic          r_dp;
  logic          w_wrap;
  logic          w_frame_end;

  // Wrap is judged on the value about to be captured versus the one held.
  assign w_wrap = ( updown && (r_cnt_q == 4'hF) && (count == 4'h0)) ||
                  (!updown && (r_cnt_q == 4'h0) && (count == 4'hF));
  assign w_frame_end = w_tick && (r_state == SCAN_DIR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
      r_dp   <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_hold <= HW'(WRAP_HOLD);
      end else if (w_frame_end && (r_hold != '0)) begin
        r_hold <= r_hold - HW'(1);
      end
      r_dp <= en && (r_hold != '0) && (r_state == SCAN_VAL);
    end
  end

  assign dp = r_dp;
`else
  assign dp = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (REFRESH_DIV=4, WRAP_HOLD=2) against a
// cycle-count based reference model; dp expectations follow SEG_SCAN_DP_WRAP_EN.
module tb_seg_scan_driver;

  localparam int RD = 4;
  localparam int WH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count = 4'd0;
  logic       updown = 1'b0;
  logic       en = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference glyph table, written out from the display definition.
  logic [6:0] gly [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model state: edges since reset, previously captured inputs, hold frames.
  int         m_k    = 0;
  logic [3:0] m_prev = 4'd0;
  logic       m_dir  = 1'b0;
  int         m_hold = 0;
  logic [6:0] exp_seg;
  logic [1:0] exp_dig;
  logic       exp_dp;

  seg_scan_driver #(
    .REFRESH_DIV (RD),
    .WRAP_HOLD   (WH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .count  (count),
    .updown (updown),
    .en     (en),
    .seg    (seg),
    .dp     (dp),
    .digit  (digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic bit dp_built();
`ifdef SEG_SCAN_DP_WRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs, advance the model by one edge, then check.
  task automatic step(input logic [3:0] c, input logic d, input logic e, input logic r);
    bit in_val;
    bit wrap;
    bit frame_end;
    count = c; updown = d; en = e; rst = r;
    @(posedge clk);
    if (r) begin
      m_k = 0; m_prev = 4'd0; m_dir = 1'b0; m_hold = 0;
      exp_seg = 7'h00; exp_dig = 2'b00; exp_dp = 1'b0;
    end else begin
      m_k++;
      in_val = (((m_k - 1) / RD) % 2) == 0;
      if (!e) begin
        exp_seg = 7'h00; exp_dig = 2'b00; exp_dp = 1'b0;
      end else if (in_val) begin
        exp_seg = gly[m_prev]; exp_dig = 2'b01;
        exp_dp  = dp_built() && (m_hold > 0);
      end else begin
        exp_seg = m_dir ? 7'h3E : 7'h5E; exp_dig = 2'b10; exp_dp = 1'b0;
      end
      wrap = (d && m_prev == 4'hF && c == 4'h0) || (!d && m_prev == 4'h0 && c == 4'hF);
      frame_end = !in_val && (m_k % RD == 0);
      if (wrap) m_hold = WH;
      else if (frame_end && m_hold > 0) m_hold--;
      m_prev = c; m_dir = d;
    end
    #1;
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("digit", 32'(digit), 32'(exp_dig));
    chk("dp", 32'(dp), 32'(exp_dp));
    if (exp_dig != 2'b00) chk("onehot", 32'($countones(digit)), 32'd1);
  endtask

  logic [3:0] rc;
  logic       rd_dir;

  initial begin
    // Reset held 3 cycles, then count=5 up enabled.
    for (int i = 0; i < 3; i++) step(4'd5, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(4'd5, 1'b1, 1'b1, 1'b0);
    // Direction switched to down.
    for (int i = 0; i < 16; i++) step(4'd5, 1'b0, 1'b1, 1'b0);
    // Glyph sweep, one frame per value (up direction keeps clear of wraps).
    for (int v = 1; v < 16; v++)
      for (int i = 0; i < 2 * RD; i++) step(4'(v), 1'b1, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2 * RD; i++) step(4'h0, 1'b0, 1'b1, 1'b0);
    // Blank mid-scan then resume.
    for (int i = 0; i < 3; i++) step(4'h9, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(4'h9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(4'h9, 1'b1, 1'b1, 1'b0);
    // Up wrap F->0, then down wrap 0->F during the hold.
    for (int i = 0; i < 8; i++) step(4'hF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(4'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 28; i++) step(4'hF, 1'b0, 1'b1, 1'b0);
    // Reset mid-SCAN_DIR while a hold is active.
    step(4'hF, 1'b1, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2 * RD && ((m_k / RD) % 2) == 0; i++) step(4'h0, 1'b1, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(4'h0, 1'b1, 1'b1, 1'b0);
    // Randomized traffic: mostly single steps so wraps occur, occasional jumps.
    rc = 4'h7; rd_dir = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) rd_dir = ~rd_dir;
      if ($urandom_range(0, 2) == 0) rc = rd_dir ? rc + 4'd1 : rc - 4'd1;
      if ($urandom_range(0, 29) == 0) rc = 4'($urandom_range(0, 15));
      step(rc, rd_dir, ($urandom_range(0, 9) != 0), ($urandom_range(0, 79) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
